// File: rtl/altair_panel_pkg.sv
// ============================================================================
// Module      : altair_panel_pkg
// Description : Shared definitions for the front-panel command path.
//               - Command code encoding driven onto cmd_code.
//               - Sequencer state encoding. ST_REPEAT is present only when
//                 REPEAT_AUTO_EN is defined.
//               - Button index constants into the 6-bit button vector
//                 {reset, deposit_next, deposit, examine_next, examine, step}.
//               - Helper functions for priority selection and the
//                 auto-repeat button mask.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package altair_panel_pkg;

  // Button positions in btn_raw / debounced vectors
  localparam int NUM_BTNS         = 6;
  localparam int BTN_STEP         = 0;
  localparam int BTN_EXAMINE      = 1;
  localparam int BTN_EXAMINE_NEXT = 2;
  localparam int BTN_DEPOSIT      = 3;
  localparam int BTN_DEPOSIT_NEXT = 4;
  localparam int BTN_RESET        = 5;

  // Command codes offered to the machine
  localparam logic [2:0] CMD_NONE         = 3'd0;
  localparam logic [2:0] CMD_STEP         = 3'd1;
  localparam logic [2:0] CMD_EXAMINE      = 3'd2;
  localparam logic [2:0] CMD_EXAMINE_NEXT = 3'd3;
  localparam logic [2:0] CMD_DEPOSIT      = 3'd4;
  localparam logic [2:0] CMD_DEPOSIT_NEXT = 3'd5;
  localparam logic [2:0] CMD_RESET        = 3'd6;

  // Sequencer states
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_ISSUE        = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
`ifdef REPEAT_AUTO_EN
  localparam logic [1:0] ST_REPEAT       = 2'd3;
`endif

  // Fixed priority: reset > deposit > deposit_next > examine > examine_next > step.
  // Step is only honoured while the machine is paused; reset always is.
  function automatic logic [2:0] select_cmd(input logic [NUM_BTNS-1:0] press,
                                            input logic                 paused);
    if (press[BTN_RESET])             select_cmd = CMD_RESET;
    else if (press[BTN_DEPOSIT])      select_cmd = CMD_DEPOSIT;
    else if (press[BTN_DEPOSIT_NEXT]) select_cmd = CMD_DEPOSIT_NEXT;
    else if (press[BTN_EXAMINE])      select_cmd = CMD_EXAMINE;
    else if (press[BTN_EXAMINE_NEXT]) select_cmd = CMD_EXAMINE_NEXT;
    else if (press[BTN_STEP] && paused) select_cmd = CMD_STEP;
    else                              select_cmd = CMD_NONE;
  endfunction

  // One-hot mask of the button that keeps an auto-repeating command alive;
  // all-zero for commands that never repeat.
  function automatic logic [NUM_BTNS-1:0] repeat_mask(input logic [2:0] code);
    repeat_mask = '0;
    case (code)
      CMD_STEP:         repeat_mask[BTN_STEP]         = 1'b1;
      CMD_EXAMINE_NEXT: repeat_mask[BTN_EXAMINE_NEXT] = 1'b1;
      CMD_DEPOSIT_NEXT: repeat_mask[BTN_DEPOSIT_NEXT] = 1'b1;
      default:          repeat_mask = '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : One front-panel button: 2-FF synchroniser followed by a
//               counting debouncer. The debounced level flips only after
//               DEBOUNCE_CYCLES consecutive synchronised samples that differ
//               from it. A press pulse (one cycle) accompanies a 0->1 flip.
//               After reset a button must first be seen released before any
//               press is reported, so a button held through reset is silent.
// Ports       : clk        - clock
//               resetn     - asynchronous active-low reset
//               i_btn_raw  - raw button, asynchronous to clk
//               o_btn_db   - debounced level
//               o_press    - one-cycle press event
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_btn_raw,
  output logic o_btn_db,
  output logic o_press
);

  localparam int                 c_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic [1:0]         r_fill;   // marks when r_sync2 holds a real sample after reset
  logic               r_armed;  // a released level has been observed since reset
  logic               r_state;
  logic               r_press;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_fill  <= 2'b00;
      r_armed <= 1'b0;
      r_state <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      r_fill  <= {r_fill[0], 1'b1};
      r_press <= 1'b0;

      if (r_fill[1] && !r_sync2 && !r_state) begin
        r_armed <= 1'b1;
      end

      if (r_sync2 == r_state) begin
        r_cnt <= '0;
      end else if (r_cnt == c_CNT_LAST) begin
        r_cnt   <= '0;
        r_state <= r_sync2;
        r_press <= r_sync2 & r_armed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_btn_db = r_state;
  assign o_press  = r_press;

endmodule

`default_nettype wire

// File: rtl/panel_cmd_sequencer.sv
// ============================================================================
// Module      : panel_cmd_sequencer
// Description : Turns debounced front-panel button presses into single
//               commands handed to the machine over a valid/ready handshake.
//               Same-cycle presses resolve by fixed priority; presses while a
//               command is outstanding or buttons are still held are dropped.
//               Optional feature macro: REPEAT_AUTO_EN - step, examine_next
//               and deposit_next auto-repeat while held (REPEAT_DELAY cycles
//               after the handshake, then every REPEAT_PERIOD cycles).
// Ports       : clk        - clock (machine clock domain)
//               resetn     - asynchronous active-low reset
//               btn_raw    - raw buttons {reset, deposit_next, deposit,
//                            examine_next, examine, step}
//               pause_mode - 1 = machine paused, step allowed
//               data_sw    - data/address switches, captured at acceptance
//               cmd_valid  - command offered
//               cmd_code   - command code (altair_panel_pkg)
//               cmd_data   - data_sw captured with the command
//               cmd_ready  - machine accepts the command
//               busy       - sequencer is not idle
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module panel_cmd_sequencer
  import altair_panel_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_BTNS-1:0] btn_raw,
  input  logic                pause_mode,
  input  logic [7:0]          data_sw,
  output logic                cmd_valid,
  output logic [2:0]          cmd_code,
  output logic [7:0]          cmd_data,
  input  logic                cmd_ready,
  output logic                busy
);

  logic [NUM_BTNS-1:0] w_db;
  logic [NUM_BTNS-1:0] w_press;
  logic [2:0]          w_sel;

  logic [1:0]          r_state;
  logic                r_cmd_valid;
  logic [2:0]          r_cmd_code;
  logic [7:0]          r_cmd_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
      btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_btn_debounce (
        .clk       (clk),
        .resetn    (resetn),
        .i_btn_raw (btn_raw[gi]),
        .o_btn_db  (w_db[gi]),
        .o_press   (w_press[gi])
      );
    end
  endgenerate

  assign w_sel = select_cmd(w_press, pause_mode);

`ifdef REPEAT_AUTO_EN
  localparam int                 c_REP_MAX     = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int                 c_REP_W       = $clog2(c_REP_MAX + 1);
  localparam logic [c_REP_W-1:0] c_DELAY_LAST  = c_REP_W'(REPEAT_DELAY - 1);
  localparam logic [c_REP_W-1:0] c_PERIOD_LAST = c_REP_W'(REPEAT_PERIOD - 1);

  // r_rep_cnt reads k in the k-th cycle after a handshake; the reissue is
  // registered one cycle ahead so the next cmd_valid lands exactly on the
  // delay/period boundary.
  logic [c_REP_W-1:0] r_rep_cnt;
  logic               r_rep_first;
  logic               w_rep_held;

  assign w_rep_held = |(w_db & repeat_mask(r_cmd_code));
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= CMD_NONE;
      r_cmd_data  <= 8'h00;
`ifdef REPEAT_AUTO_EN
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_sel != CMD_NONE) begin
            r_cmd_code  <= w_sel;
            r_cmd_data  <= data_sw;
            r_cmd_valid <= 1'b1;
            r_state     <= ST_ISSUE;
`ifdef REPEAT_AUTO_EN
            r_rep_first <= 1'b1;
`endif
          end
        end

        ST_ISSUE: begin
          if (cmd_ready) begin
            r_cmd_valid <= 1'b0;
`ifdef REPEAT_AUTO_EN
            if (|repeat_mask(r_cmd_code)) begin
              r_rep_cnt <= c_REP_W'(1);
              r_state   <= ST_REPEAT;
            end else begin
              r_state   <= ST_WAIT_RELEASE;
            end
`else
            r_state     <= ST_WAIT_RELEASE;
`endif
          end
        end

        ST_WAIT_RELEASE: begin
          if (w_db == '0) begin
            r_state <= ST_IDLE;
          end
        end

`ifdef REPEAT_AUTO_EN
        ST_REPEAT: begin
          if (!w_rep_held) begin
            r_state <= ST_IDLE;
          end else if (r_rep_cnt >= (r_rep_first ? c_DELAY_LAST : c_PERIOD_LAST)) begin
            r_cmd_valid <= 1'b1;
            r_rep_first <= 1'b0;
            r_state     <= ST_ISSUE;
          end else if (r_rep_cnt != '1) begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
`endif

        default: begin
          r_state     <= ST_IDLE;
          r_cmd_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_code  = r_cmd_code;
  assign cmd_data  = r_cmd_data;
  assign busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_panel_cmd_sequencer.sv
// ============================================================================
// Module      : tb_panel_cmd_sequencer
// Description : Self-checking bench for panel_cmd_sequencer with
//               DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8.
//               Directed scenarios plus randomized press/glitch scenarios,
//               scored against a transaction-level queue of expected commands.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_panel_cmd_sequencer;
  import altair_panel_pkg::*;

  localparam int c_DB   = 4;
  localparam int c_RD   = 20;
  localparam int c_RP   = 8;
  localparam int c_HOLD = 50;

  logic       clk = 1'b0;
  logic       resetn;
  logic [5:0] btn_raw;
  logic       pause_mode;
  logic [7:0] data_sw;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [7:0] cmd_data;
  logic       busy;

  always #5 clk = ~clk;

  panel_cmd_sequencer #(
    .DEBOUNCE_CYCLES (c_DB),
    .REPEAT_DELAY    (c_RD),
    .REPEAT_PERIOD   (c_RP)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_raw    (btn_raw),
    .pause_mode (pause_mode),
    .data_sw    (data_sw),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_data   (cmd_data),
    .cmd_ready  (cmd_ready),
    .busy       (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Scoreboard: commands the machine should see, in order
  typedef struct packed {
    logic [2:0] code;
    logic [7:0] data;
  } cmd_t;

  cmd_t exp_q[$];
  int   hs_cnt = 0;
  int   cyc    = 0;
  int   hs_cyc[$];
  logic rnd_ready = 1'b0;

  always @(posedge clk) cyc++;

  // Random back-pressure and data switch scrambling while a command is up
  always @(posedge clk) begin
    #1;
    if (rnd_ready) cmd_ready = 1'($urandom_range(0, 1));
    if (cmd_valid) data_sw = 8'($urandom);
  end

  always @(negedge clk) begin
    if (resetn === 1'b1 && cmd_valid === 1'b1) begin
      check_eq("valid_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        check_eq("cmd_code", 32'(cmd_code), 32'(exp_q[0].code));
        check_eq("cmd_data", 32'(cmd_data), 32'(exp_q[0].data));
        if (cmd_ready) begin
          void'(exp_q.pop_front());
          hs_cnt++;
          hs_cyc.push_back(cyc);
        end
      end
    end
  end

  // Reference: highest-priority pressed button wins; step needs pause
  function automatic logic [2:0] model_cmd(input logic [5:0] m, input logic p);
    int         order [6] = '{5, 3, 4, 1, 2, 0};
    logic [2:0] codes [6] = '{3'd6, 3'd4, 3'd5, 3'd2, 3'd3, 3'd1};
    model_cmd = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (m[order[i]] && (order[i] != 0 || p)) return codes[i];
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [5:0] mask, input int len);
    btn_raw = mask;
    tick(len);
    btn_raw = 6'b0;
  endtask

  task automatic wait_idle();
    int budget = 0;
    tick(c_DB + 8);
    while (busy && budget < 400) begin
      tick(1);
      budget++;
    end
    check_eq("idle_reached", 32'(busy), 0);
    tick(c_DB + 4);
    check_eq("sb_drained", exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (cmd_valid) found = 1'b1;
    end
    check_eq(tag, 32'(found), 1);
  endtask

  initial begin
    int   hs0;
    int   n_exp;
    int   exp_off[$];
    int   kind;
    int   len;
    logic [5:0] mask;
    logic [2:0] c;

    resetn     = 1'b0;
    btn_raw    = 6'b0;
    pause_mode = 1'b0;
    data_sw    = 8'h00;
    cmd_ready  = 1'b0;
    tick(3);
    check_eq("rst_valid", 32'(cmd_valid), 0);
    check_eq("rst_code",  32'(cmd_code),  0);
    check_eq("rst_data",  32'(cmd_data),  0);
    check_eq("rst_busy",  32'(busy),      0);
    resetn = 1'b1;
    tick(6);

    // Examine held 10 cycles, ready tied high
    cmd_ready = 1'b1;
    data_sw   = 8'h3C;
    exp_q.push_back('{code: 3'd2, data: 8'h3C});
    hs0 = hs_cnt;
    press(6'b000010, 10);
    wait_idle();
    check_eq("examine_count", hs_cnt - hs0, 1);

    // 3-cycle glitch on deposit
    hs0 = hs_cnt;
    press(6'b001000, 3);
    wait_idle();
    check_eq("glitch_count", hs_cnt - hs0, 0);

    // Deposit and step together while paused
    pause_mode = 1'b1;
    data_sw    = 8'h5A;
    exp_q.push_back('{code: 3'd4, data: 8'h5A});
    hs0 = hs_cnt;
    press(6'b001001, 8);
    wait_idle();
    check_eq("dep_step_count", hs_cnt - hs0, 1);

    // Step ignored while running, accepted while paused
    pause_mode = 1'b0;
    hs0 = hs_cnt;
    press(6'b000001, 8);
    wait_idle();
    check_eq("step_run_count", hs_cnt - hs0, 0);
    pause_mode = 1'b1;
    data_sw    = 8'h11;
    exp_q.push_back('{code: 3'd1, data: 8'h11});
    press(6'b000001, 8);
    wait_idle();
    check_eq("step_pause_count", hs_cnt - hs0, 1);

    // Back-pressure: ready low for 7 cycles
    cmd_ready = 1'b0;
    data_sw   = 8'hA5;
    exp_q.push_back('{code: 3'd4, data: 8'hA5});
    hs0 = hs_cnt;
    btn_raw = 6'b001000;
    wait_valid("bp_valid_seen");
    for (int k = 1; k <= 7; k++) begin
      check_eq("bp_hold_valid", 32'(cmd_valid), 1);
      @(posedge clk);
      #1;
      if (k == 7) cmd_ready = 1'b1;
      @(negedge clk);
    end
    check_eq("bp_hs_valid", 32'(cmd_valid), 1);
    @(negedge clk);
    check_eq("bp_drop_valid", 32'(cmd_valid), 0);
    tick(1);
    btn_raw = 6'b0;
    wait_idle();
    check_eq("bp_count", hs_cnt - hs0, 1);

    // Reset in the middle of ISSUE, button held through reset
    cmd_ready = 1'b0;
    data_sw   = 8'h42;
    exp_q.push_back('{code: 3'd2, data: 8'h42});
    btn_raw = 6'b000010;
    wait_valid("rst_mid_valid_seen");
    #2;
    resetn = 1'b0;
    #1;
    check_eq("rst_mid_valid", 32'(cmd_valid), 0);
    check_eq("rst_mid_busy",  32'(busy),      0);
    check_eq("rst_mid_code",  32'(cmd_code),  0);
    check_eq("rst_mid_data",  32'(cmd_data),  0);
    exp_q.delete();
    tick(3);
    resetn    = 1'b1;
    cmd_ready = 1'b1;
    hs0 = hs_cnt;
    tick(25);
    check_eq("held_thru_rst_count", hs_cnt - hs0, 0);
    btn_raw = 6'b0;
    tick(c_DB + 6);
    exp_q.push_back('{code: 3'd2, data: data_sw});
    press(6'b000010, 8);
    wait_idle();
    check_eq("repress_count", hs_cnt - hs0, 1);

    // examine_next held: auto-repeat timing (single command without the feature)
    cmd_ready = 1'b1;
    data_sw   = 8'h77;
    n_exp     = 1;
    exp_off.push_back(0);
`ifdef REPEAT_AUTO_EN
    for (int off = c_RD; off < c_HOLD; off += c_RP) begin
      n_exp++;
      exp_off.push_back(off);
    end
`endif
    for (int i = 0; i < n_exp; i++) exp_q.push_back('{code: 3'd3, data: 8'h77});
    hs_cyc.delete();
    hs0 = hs_cnt;
    press(6'b000100, c_HOLD);
    wait_idle();
    check_eq("repeat_count", hs_cnt - hs0, n_exp);
    for (int i = 1; i < n_exp; i++) begin
      if (i < hs_cyc.size()) check_eq("repeat_offset", hs_cyc[i] - hs_cyc[0], exp_off[i]);
    end

    // Randomized presses and glitches with random back-pressure
    rnd_ready = 1'b1;
    for (int it = 0; it < 40; it++) begin
      kind       = int'($urandom_range(0, 3));
      mask       = 6'($urandom_range(1, 63));
      pause_mode = 1'($urandom_range(0, 1));
      data_sw    = 8'($urandom);
      hs0        = hs_cnt;
      n_exp      = 0;
      if (kind == 0) begin
        len = int'($urandom_range(1, c_DB - 1));
      end else begin
        len = int'($urandom_range(c_DB + 1, 12));
        c   = model_cmd(mask, pause_mode);
        if (c != 3'd0) begin
          exp_q.push_back('{code: c, data: data_sw});
          n_exp = 1;
        end
      end
      press(mask, len);
      wait_idle();
      check_eq("rand_count", hs_cnt - hs0, n_exp);
    end
    rnd_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/panel_cmd_sequencer.md
PANEL_CMD_SEQUENCER -- requirements
Module: panel_cmd_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 250000, cycles an input must stay stable before it is accepted (10 ms at 25 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 12500000, hold cycles before the first auto-repeat.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2500000, cycles between subsequent auto-repeats.
REQ-004 SHALL have port clk, input, 1, the single clock (pixel/machine clock domain).
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port btn_raw, input, 6, raw buttons {reset, deposit_next, deposit, examine_next, examine, step}, active-high, asynchronous to clk.
REQ-007 SHALL have port pause_mode, input, 1, level; 1 = machine paused (single-step allowed).
REQ-008 SHALL have port data_sw, input, 8, front-panel data/address switches.
REQ-009 SHALL have port cmd_valid, output, 1, command offered to the machine.
REQ-010 SHALL have port cmd_code, output, 3, command code from the shared package.
REQ-011 SHALL have port cmd_data, output, 8, data_sw sampled at command issue.
REQ-012 SHALL have port cmd_ready, input, 1, machine accepts the command.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-014 SHALL pass each btn_raw bit through a 2-FF synchroniser, then a debouncer that changes its debounced state only after DEBOUNCE_CYCLES consecutive identical synchronised samples.
REQ-015 SHALL treat a 0->1 transition of a debounced bit as a press event, valid for one cycle.
REQ-016 SHALL implement states IDLE, ISSUE, WAIT_RELEASE and, when REPEAT_AUTO_EN is defined, REPEAT.
REQ-017 In IDLE, SHALL select among same-cycle press events by fixed priority reset > deposit > deposit_next > examine > examine_next > step, and drop all lower-priority events.
REQ-018 SHALL ignore a step press when pause_mode=0; a reset press SHALL be accepted regardless of pause_mode.
REQ-019 On acceptance, SHALL register cmd_code and cmd_data (from data_sw that cycle) and assert cmd_valid the next cycle (ISSUE).
REQ-020 In ISSUE, cmd_valid, cmd_code and cmd_data SHALL hold stable until the cycle cmd_valid and cmd_ready are both high; cmd_valid SHALL drop the following cycle.
REQ-021 SHALL move from ISSUE to WAIT_RELEASE on handshake; a simultaneous cmd_ready on the first valid cycle SHALL complete in one cycle.
REQ-022 SHALL drop press events arriving in ISSUE, WAIT_RELEASE or REPEAT; no queueing.
REQ-023 In WAIT_RELEASE, SHALL return to IDLE once all six debounced bits are 0.
REQ-024 REPEAT_DELAY and REPEAT_PERIOD counters SHALL saturate and never wrap.

Reset
REQ-025 On resetn=0, SHALL enter IDLE asynchronously and drive cmd_valid=0, cmd_code=CMD_NONE, cmd_data=0, busy=0.
REQ-026 SHALL clear debouncer counters and states to 0, so buttons held through reset produce a press only after release and re-press.
REQ-027 Reset asserted mid-handshake SHALL abort the command with no further cmd_valid.

Configuration
REQ-028 SHALL use macro REPEAT_AUTO_EN.
REQ-029 With REPEAT_AUTO_EN defined, a step, examine_next or deposit_next button held REPEAT_DELAY cycles after handshake SHALL reissue the same command, then again every REPEAT_PERIOD cycles while held; release SHALL return to IDLE.
REQ-030 Without REPEAT_AUTO_EN, no REPEAT state or repeat counters SHALL exist; every press yields exactly one command.

Structure
REQ-031 Package altair_panel_pkg SHALL hold the cmd_code encoding (CMD_NONE=0, STEP=1, EXAMINE=2, EXAMINE_NEXT=3, DEPOSIT=4, DEPOSIT_NEXT=5, RESET=6), the state encoding and the button index constants.
REQ-032 Sub-module btn_debounce (synchroniser plus counter, one instance per button) SHALL be the only sub-module.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8)
REQ-033 Examine held 10 cycles, data_sw=0x3C, cmd_ready tied 1 -> exactly one cmd_valid pulse, cmd_code=2, cmd_data=0x3C.
REQ-034 Glitch of 3 cycles on deposit -> no cmd_valid.
REQ-035 Deposit and step pressed the same cycle, pause_mode=1 -> single command, cmd_code=4; step dropped.
REQ-036 Step press with pause_mode=0 -> no command; same press with pause_mode=1 -> cmd_code=1.
REQ-037 cmd_ready held 0 for 7 cycles -> cmd_valid and cmd_code/cmd_data stable for 8 cycles, then deassert the cycle after handshake.
REQ-038 With REPEAT_AUTO_EN, examine_next held 50 cycles after debounce -> commands at handshake, +20, +28, +36, +44; without it, one command only; resetn pulse mid-ISSUE -> cmd_valid=0 immediately.
